// File: rtl/ps2_speed_gear_ctrl.sv
// PS/2 scan-code decoder driving a speed/gear model with BCD speed digits.
// Speed advances on a divided tick; gear changes follow key presses.
module ps2_speed_gear_ctrl #(
    parameter int TICK_DIV   = 5000000,
    parameter int MAX_GEAR   = 5,
    parameter int GEAR_SPAN  = 19,
    parameter int BRAKE_STEP = 3
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [6:0] speed,
    output logic [3:0] speed_tens,
    output logic [3:0] speed_ones,
    output logic [2:0] gear,
    output logic       accel_held,
    output logic       brake_held
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [7:0] K_W   = 8'h1D;
    localparam logic [7:0] K_S   = 8'h1B;
    localparam logic [7:0] K_UP  = 8'h24;
    localparam logic [7:0] K_DN  = 8'h15;
    localparam logic [7:0] P_BRK = 8'hF0;
    localparam logic [7:0] P_EXT = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXTBRK
    } dec_t;

    dec_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]  speed_q, speed_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic [2:0]  gear_q, gear_d;
    logic        accel_q, accel_d;
    logic        brake_q, brake_d;
    logic        up_q, up_d;
    logic        dn_q, dn_d;

    logic        tick;
    logic        make_ev;
    logic        brk_ev;
    logic        gear_up;
    logic        gear_dn;
    logic [7:0]  spd8;
    logic [7:0]  cap_cur;
    logic [7:0]  cap_low;
    logic [7:0]  nxt;
    logic [3:0]  tens_v;

    function automatic logic [7:0] cap_of(input logic [2:0] g);
        logic [15:0] c;
        c = 16'(g) * 16'(GEAR_SPAN);
        return (c > 16'd99) ? 8'd99 : 8'(c);
    endfunction

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        speed_d = speed_q;
        gear_d  = gear_q;
        accel_d = accel_q;
        brake_d = brake_q;
        up_d    = up_q;
        dn_d    = dn_q;
        make_ev = 1'b0;
        brk_ev  = 1'b0;
        gear_up = 1'b0;
        gear_dn = 1'b0;
        spd8    = {1'b0, speed_q};
        cap_cur = cap_of(gear_q);
        cap_low = cap_of(3'(gear_q - 3'd1));
        nxt     = spd8 + 8'd1;
        tens_v  = 4'd0;

        if (scan_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (scan_code == P_EXT) state_d = EXT;
                    else if (scan_code == P_BRK) state_d = BRK;
                    else make_ev = 1'b1;
                end
                BRK: begin
                    brk_ev  = 1'b1;
                    state_d = IDLE;
                end
                EXT: state_d = (scan_code == P_BRK) ? EXTBRK : IDLE;
                EXTBRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Gear keys only act on the first make after a break.
        if (make_ev) begin
            unique case (1'b1)
                scan_code == K_W: accel_d = 1'b1;
                scan_code == K_S: brake_d = 1'b1;
                scan_code == K_UP: begin
                    up_d    = 1'b1;
                    gear_up = !up_q;
                end
                scan_code == K_DN: begin
                    dn_d    = 1'b1;
                    gear_dn = !dn_q;
                end
                default: ;
            endcase
        end

        if (brk_ev) begin
            unique case (1'b1)
                scan_code == K_W:  accel_d = 1'b0;
                scan_code == K_S:  brake_d = 1'b0;
                scan_code == K_UP: up_d = 1'b0;
                scan_code == K_DN: dn_d = 1'b0;
                default: ;
            endcase
        end

        if (gear_up && gear_q < 3'(MAX_GEAR))
            gear_d = gear_q + 3'd1;
        if (gear_dn && gear_q > 3'd1 && spd8 <= cap_low)
            gear_d = gear_q - 3'd1;

        if (tick) begin
            if (brake_q)
                speed_d = (spd8 > 8'(BRAKE_STEP)) ? 7'(spd8 - 8'(BRAKE_STEP)) : 7'd0;
            else if (accel_q)
                speed_d = (nxt > cap_cur) ? 7'(cap_cur) : 7'(nxt);
            else if (speed_q != 7'd0)
                speed_d = speed_q - 7'd1;
        end

        // Comparator chain instead of a divider for the tens digit.
        for (int i = 1; i <= 9; i++)
            if (spd8 >= 8'(10 * i)) tens_v = 4'(i);
        tens_d = tens_v;
        ones_d = 4'(spd8 - 8'(tens_v) * 8'd10);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            speed_q <= 7'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            gear_q  <= 3'd1;
            accel_q <= 1'b0;
            brake_q <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            speed_q <= speed_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            gear_q  <= gear_d;
            accel_q <= accel_d;
            brake_q <= brake_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
        end
    end

    assign speed      = speed_q;
    assign speed_tens = tens_q;
    assign speed_ones = ones_q;
    assign gear       = gear_q;
    assign accel_held = accel_q;
    assign brake_held = brake_q;

endmodule

// File: tb/tb_ps2_speed_gear_ctrl.sv
// Bench for ps2_speed_gear_ctrl with TICK_DIV=4: vector table with a
// scoreboard queue, plus hand sequences for digit latency and async reset.
module tb_ps2_speed_gear_ctrl;

    logic       clk;
    logic       resetn;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic [6:0] speed;
    logic [3:0] speed_tens;
    logic [3:0] speed_ones;
    logic [2:0] gear;
    logic       accel_held;
    logic       brake_held;

    ps2_speed_gear_ctrl #(
        .TICK_DIV(4)
    ) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .speed     (speed),
        .speed_tens(speed_tens),
        .speed_ones(speed_ones),
        .gear      (gear),
        .accel_held(accel_held),
        .brake_held(brake_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         nb;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         nt;
        int         s;
        int         g;
        int         a;
        int         b;
    } vec_t;

    typedef struct {
        int s;
        int g;
        int a;
        int b;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n;
    int   total;
    int   passed;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // One posedge per step; n counts posedges since reset release.
    task automatic step();
        @(negedge clk);
        n++;
    endtask

    // Counter wraps on edges where n%4==0, so this crosses exactly one tick.
    task automatic tick();
        do step(); while (n % 4 != 1);
    endtask

    task automatic send(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        step();
        scan_valid = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic chk_all(input string p, input exp_t e);
        chk({p, " speed"}, int'(speed), e.s);
        chk({p, " tens"}, int'(speed_tens), e.s / 10);
        chk({p, " ones"}, int'(speed_ones), e.s % 10);
        chk({p, " gear"}, int'(gear), e.g);
        chk({p, " accel"}, int'(accel_held), e.a);
        chk({p, " brake"}, int'(brake_held), e.b);
    endtask

    task automatic add(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input int nt, input int s,
                       input int g, input int a, input int b);
        vec_t v;
        v.nb = nb; v.b0 = b0; v.b1 = b1; v.b2 = b2;
        v.nt = nt; v.s = s; v.g = g; v.a = a; v.b = b;
        tbl.push_back(v);
    endtask

    initial begin
        exp_t e;
        exp_t r;
        vec_t v;
        total = 0;
        passed = 0;
        n = 0;
        r = '{0, 1, 0, 0};

        // bytes, ticks, expected speed/gear/accel/brake
        add(1, 8'h1D, 8'h00, 8'h00, 30, 19, 1, 1, 0);
        add(1, 8'h24, 8'h00, 8'h00, 30, 38, 2, 1, 0);
        add(1, 8'h15, 8'h00, 8'h00, 1, 38, 2, 1, 0);
        add(1, 8'h1B, 8'h00, 8'h00, 1, 35, 2, 1, 1);
        add(0, 8'h00, 8'h00, 8'h00, 6, 17, 2, 1, 1);
        add(2, 8'hF0, 8'h15, 8'h00, 1, 14, 2, 1, 1);
        add(1, 8'h15, 8'h00, 8'h00, 1, 11, 1, 1, 1);
        add(2, 8'hF0, 8'h1B, 8'h00, 1, 12, 1, 1, 0);
        add(2, 8'hF0, 8'h1D, 8'h00, 1, 11, 1, 0, 0);
        add(0, 8'h00, 8'h00, 8'h00, 1, 10, 1, 0, 0);
        add(2, 8'h1D, 8'h1B, 8'h00, 1, 7, 1, 1, 1);
        add(0, 8'h00, 8'h00, 8'h00, 1, 4, 1, 1, 1);
        add(0, 8'h00, 8'h00, 8'h00, 1, 1, 1, 1, 1);
        add(0, 8'h00, 8'h00, 8'h00, 1, 0, 1, 1, 1);
        add(0, 8'h00, 8'h00, 8'h00, 1, 0, 1, 1, 1);
        add(2, 8'hF0, 8'h1B, 8'h00, 1, 1, 1, 1, 0);
        add(0, 8'h00, 8'h00, 8'h00, 4, 5, 1, 1, 0);
        add(2, 8'hF0, 8'h1D, 8'h00, 1, 4, 1, 0, 0);
        add(0, 8'h00, 8'h00, 8'h00, 3, 1, 1, 0, 0);
        add(0, 8'h00, 8'h00, 8'h00, 1, 0, 1, 0, 0);
        add(1, 8'h1C, 8'h00, 8'h00, 1, 0, 1, 0, 0);
        add(2, 8'hE0, 8'h1D, 8'h00, 1, 0, 1, 0, 0);
        add(1, 8'h1B, 8'h00, 8'h00, 1, 0, 1, 0, 1);
        add(3, 8'hE0, 8'hF0, 8'h1B, 1, 0, 1, 0, 1);
        add(2, 8'hF0, 8'h1B, 8'h00, 1, 0, 1, 0, 0);
        add(3, 8'hF0, 8'h24, 8'h24, 1, 0, 2, 0, 0);
        add(2, 8'h24, 8'h24, 8'h00, 1, 0, 2, 0, 0);
        add(3, 8'hF0, 8'h24, 8'h24, 1, 0, 3, 0, 0);
        add(3, 8'hF0, 8'h24, 8'h24, 1, 0, 4, 0, 0);
        add(3, 8'hF0, 8'h24, 8'h24, 1, 0, 5, 0, 0);
        add(3, 8'hF0, 8'h24, 8'h24, 1, 0, 5, 0, 0);
        add(3, 8'hF0, 8'h15, 8'h15, 1, 0, 4, 0, 0);
        add(1, 8'h15, 8'h00, 8'h00, 1, 0, 4, 0, 0);
        add(1, 8'h1D, 8'h00, 8'h00, 5, 5, 4, 1, 0);

        resetn     = 1'b0;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        repeat (3) @(negedge clk);
        chk_all("reset", r);
        resetn = 1'b1;
        n = 0;
        step();

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            sb.push_back('{v.s, v.g, v.a, v.b});
            if (v.nb > 0) send(v.b0);
            if (v.nb > 1) send(v.b1);
            if (v.nb > 2) send(v.b2);
            repeat (v.nt) tick();
            if (sb.size() == 0) begin
                chk($sformatf("v%0d scoreboard", i), 0, 1);
            end else begin
                e = sb.pop_front();
                chk_all($sformatf("v%0d", i), e);
            end
        end

        // Digits trail speed by one cycle.
        do step(); while (n % 4 != 0);
        chk("lag speed", int'(speed), 6);
        chk("lag ones old", int'(speed_ones), 5);
        step();
        chk("lag ones new", int'(speed_ones), 6);
        chk("lag tens", int'(speed_tens), 0);

        // Asynchronous reset away from any clock edge.
        #2 resetn = 1'b0;
        #1 chk_all("async reset", r);
        @(negedge clk);
        resetn = 1'b1;
        n = 0;
        step();
        send(8'h1D);
        tick();
        chk_all("post reset", '{1, 1, 1, 0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
